in_range: RTL and testbench
===========================

Name: in_range

Overview:
- Constant-bound range checker: flags whether unsigned input dat lies in the half-open interval [LOWER_BOUND, UPPER_BOUND).
- Three selectable implementation structures (METHOD) that must be functionally identical.
- Combinational result for in-cycle use, plus a registered copy for timing-critical consumers in the clocked datapath.

Parameters:
- WIDTH, 7, bit width of dat (1..32).
- LOWER_BOUND, 85, inclusive lower bound. Constraint: 0 <= LOWER_BOUND <= 2^WIDTH.
- UPPER_BOUND, 120, exclusive upper bound. Constraint: LOWER_BOUND <= UPPER_BOUND <= 2^WIDTH.
- METHOD, 0, implementation select: 0 = two magnitude compares; 1 = offset-subtract single compare; 2 = carry-chain adders. Any other value builds as 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- dat  input  WIDTH  unsigned value under test.
- inr  output  1  combinational in-range flag.
- too_low  output  1  combinational; 1 when dat < LOWER_BOUND.
- too_high  output  1  combinational; 1 when dat >= UPPER_BOUND.
- inr_q  output  1  inr registered on clk.

Behaviour:
- inr = (dat >= LOWER_BOUND) && (dat < UPPER_BOUND), unsigned. Result is exactly identical for all METHOD values.
- too_low, too_high:
  - Always computed by direct compare, independent of METHOD.
  - Invariant: inr == !(too_low | too_high).
- METHOD 0:
  - Two independent WIDTH+1-bit constant compares, ANDed.
- METHOD 1:
  - off = (dat - LOWER_BOUND) in WIDTH+1-bit arithmetic, modulo 2^(WIDTH+1).
  - inr = off < (UPPER_BOUND - LOWER_BOUND).
  - Wrap makes values below LOWER_BOUND produce large off, so they fail the compare.
- METHOD 2:
  - c_lo = carry-out of dat + (2^WIDTH - LOWER_BOUND), WIDTH+1-bit adder.
  - c_hi = carry-out of dat + (2^WIDTH - UPPER_BOUND), WIDTH+1-bit adder.
  - inr = c_lo & ~c_hi.
  - Must handle LOWER_BOUND=0 (c_lo forced 1) and UPPER_BOUND=2^WIDTH (c_hi forced 0).
- Boundaries:
  - LOWER_BOUND == UPPER_BOUND: inr always 0.
  - LOWER_BOUND=0 and UPPER_BOUND=2^WIDTH: inr always 1.
  - dat = LOWER_BOUND: inr = 1.
  - dat = UPPER_BOUND-1: inr = 1.
  - dat = UPPER_BOUND: inr = 0.
- Combinational path:
  - inr, too_low, too_high have zero latency.
  - No dependence on clk/rst; valid during reset.
- Registered path:
  - inr_q <= inr on each rising clk edge; latency exactly 1 cycle.
  - rst asserted: inr_q goes 0 immediately (asynchronous), including mid-stream.
  - First edge after rst deasserts loads the current inr.
- No internal state other than inr_q (and mismatch_q when the optional feature is built).

Optional Feature:
- Macro IN_RANGE_CROSSCHECK_EN.
- Defined:
  - All three METHOD structures are instantiated in parallel; inr is driven by the one chosen by METHOD.
  - Adds output mismatch_q (1 bit): sticky flag set on a rising clk edge when any two structure results differ.
  - mismatch_q is cleared only by rst (asynchronous, to 0).
  - Intended for silicon/emulation self-check.
- Undefined:
  - Only the selected structure is built.
  - Port mismatch_q does not exist.

Test Plan:
- Defaults (WIDTH=7, 85..120), each METHOD 0/1/2:
  - dat=84 -> inr=0, too_low=1.
  - dat=85 -> inr=1.
  - dat=119 -> inr=1.
  - dat=120 -> inr=0, too_high=1.
  - dat=0 -> inr=0.
  - dat=127 -> inr=0.
- Exhaustive sweep of dat 0..127 on three instances (METHOD 0,1,2) -> outputs bit-identical every value; inr==!(too_low|too_high).
- Random dat every 50 time units, 1000 samples -> all three instances agree; with IN_RANGE_CROSSCHECK_EN, mismatch_q stays 0.
- Clocked: rst=1, then release; drive dat=100 then dat=50 on consecutive cycles -> inr_q reads 0 during reset, 1 one cycle after dat=100, 0 one cycle after dat=50.
- Assert rst asynchronously mid-cycle while inr_q=1 -> inr_q drops to 0 before next clk edge; combinational inr unaffected.
- Edge parameters: (LOWER=0, UPPER=128) -> inr=1 for all dat; (LOWER=40, UPPER=40) -> inr=0 for all dat; both for METHOD 0/1/2.

Source files
------------

// File: rtl/in_range.sv
// in_range: constant-bound range checker, flags dat in [LOWER_BOUND, UPPER_BOUND).
// METHOD selects the comparison structure: 0 = two magnitude compares,
// 1 = offset-subtract single compare, 2 = carry-chain adders; other values build as 0.
// Optional build macro IN_RANGE_CROSSCHECK_EN: all three structures run in parallel
// and a sticky mismatch_q output flags any disagreement between them.
module in_range #(
   parameter int unsigned      WIDTH       = 7,
   parameter longint unsigned  LOWER_BOUND = 85,
   parameter longint unsigned  UPPER_BOUND = 120,
   parameter int unsigned      METHOD      = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] dat,
   output logic             inr,
   output logic             too_low,
   output logic             too_high,
`ifdef IN_RANGE_CROSSCHECK_EN
   output logic             mismatch_q,
`endif
   output logic             inr_q
);

   // Bounds held one bit wider than dat so that 2^WIDTH is representable.
   localparam logic [WIDTH:0] LB     = (WIDTH+1)'(LOWER_BOUND);
   localparam logic [WIDTH:0] UB     = (WIDTH+1)'(UPPER_BOUND);
   localparam logic [WIDTH:0] ZERO_W = {(WIDTH+1){1'b0}};
   localparam logic [WIDTH:0] TWO_W  = {1'b1, {WIDTH{1'b0}}};
   localparam logic [WIDTH:0] RNG    = UB - LB;
   localparam logic [WIDTH:0] K_LO   = TWO_W - LB;
   localparam logic [WIDTH:0] K_HI   = TWO_W - UB;

   // Structure 0: two independent constant compares.
   function automatic logic range_cmp_f(input logic [WIDTH:0] d);
      return (d >= LB) && (d < UB);
   endfunction

   // Structure 1: values below LB wrap to >= 2^WIDTH, which never passes off < RNG.
   function automatic logic range_off_f(input logic [WIDTH:0] d);
      logic [WIDTH:0] off;
      off = d - LB;
      return (off < RNG);
   endfunction

   // Structure 2: carry out of dat + (2^WIDTH - bound) means dat >= bound.
   function automatic logic range_carry_f(input logic [WIDTH:0] d);
      logic [WIDTH:0] s_lo;
      logic [WIDTH:0] s_hi;
      logic           c_lo;
      logic           c_hi;
      s_lo = d + K_LO;
      s_hi = d + K_HI;
      if (LB == ZERO_W) begin
         c_lo = 1'b1;
      end else begin
         c_lo = s_lo[WIDTH];
      end
      if (UB == TWO_W) begin
         c_hi = 1'b0;
      end else begin
         c_hi = s_hi[WIDTH];
      end
      return c_lo & ~c_hi;
   endfunction

   logic [WIDTH:0] dat_ext;
   logic           inr_d;

`ifdef IN_RANGE_CROSSCHECK_EN
   logic r_cmp;
   logic r_off;
   logic r_carry;
   logic mismatch_d;

   // Evaluate all three structures, select one, and accumulate any disagreement.
   always_comb begin
      dat_ext  = {1'b0, dat};
      too_low  = (dat_ext < LB);
      too_high = (dat_ext >= UB);
      r_cmp    = range_cmp_f(dat_ext);
      r_off    = range_off_f(dat_ext);
      r_carry  = range_carry_f(dat_ext);
      case (METHOD)
         32'd1:   inr = r_off;
         32'd2:   inr = r_carry;
         default: inr = r_cmp;
      endcase
      inr_d      = inr;
      mismatch_d = mismatch_q | (r_cmp ^ r_off) | (r_off ^ r_carry);
   end

   // Sticky cross-check flag, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mismatch_q <= 1'b0;
      end else begin
         mismatch_q <= mismatch_d;
      end
   end
`else
   // Evaluate only the selected structure plus the direct out-of-range flags.
   always_comb begin
      dat_ext  = {1'b0, dat};
      too_low  = (dat_ext < LB);
      too_high = (dat_ext >= UB);
      case (METHOD)
         32'd1:   inr = range_off_f(dat_ext);
         32'd2:   inr = range_carry_f(dat_ext);
         default: inr = range_cmp_f(dat_ext);
      endcase
      inr_d = inr;
   end
`endif

   // Registered copy of the in-range flag for the clocked datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inr_q <= 1'b0;
      end else begin
         inr_q <= inr_d;
      end
   end

endmodule

// File: tb/tb_in_range.sv
// tb_in_range: directed and swept checks of in_range on nine instances:
// defaults (85..120), full range (0..128) and empty range (40..40), each with METHOD 0/1/2.
`timescale 1ns/1ps
module tb_in_range;

   logic       clk;
   logic       rst;
   logic [6:0] dat;
   logic [8:0] inr_v;
   logic [8:0] tlo_v;
   logic [8:0] thi_v;
   logic [8:0] inrq_v;
`ifdef IN_RANGE_CROSSCHECK_EN
   logic [8:0] mm_v;
`endif

   int n_checks = 0;
   int n_errors = 0;

   function automatic int lo_of(input int g);
      return (g < 3) ? 85 : ((g < 6) ? 0 : 40);
   endfunction

   function automatic int hi_of(input int g);
      return (g < 3) ? 120 : ((g < 6) ? 128 : 40);
   endfunction

   for (genvar g = 0; g < 9; g++) begin : g_dut
      localparam longint unsigned LO = (g < 3) ? 85 : ((g < 6) ? 0 : 40);
      localparam longint unsigned HI = (g < 3) ? 120 : ((g < 6) ? 128 : 40);
      in_range #(
         .WIDTH(7), .LOWER_BOUND(LO), .UPPER_BOUND(HI), .METHOD(g % 3)
      ) u_dut (
         .clk(clk),
         .rst(rst),
         .dat(dat),
         .inr(inr_v[g]),
         .too_low(tlo_v[g]),
         .too_high(thi_v[g]),
`ifdef IN_RANGE_CROSSCHECK_EN
         .mismatch_q(mm_v[g]),
`endif
         .inr_q(inrq_v[g])
      );
   end

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic model_inr(input int g, input int d);
      return (d >= lo_of(g)) && (d < hi_of(g));
   endfunction

   // Check combinational outputs of every instance against the model at the current dat.
   task automatic check_comb(input string tag);
      int d;
      d = int'(dat);
      for (int g = 0; g < 9; g++) begin
         check_eq($sformatf("%s_inr_g%0d_d%0d", tag, g, d), 32'(inr_v[g]), 32'(model_inr(g, d)));
         check_eq($sformatf("%s_lo_g%0d_d%0d", tag, g, d), 32'(tlo_v[g]), 32'(d < lo_of(g)));
         check_eq($sformatf("%s_hi_g%0d_d%0d", tag, g, d), 32'(thi_v[g]), 32'(d >= hi_of(g)));
      end
   endtask

   task automatic check_regs(input string tag, input int d_loaded, input logic in_reset);
      for (int g = 0; g < 9; g++) begin
         if (in_reset) begin
            check_eq($sformatf("%s_inrq_g%0d", tag, g), 32'(inrq_v[g]), 32'd0);
         end else begin
            check_eq($sformatf("%s_inrq_g%0d", tag, g), 32'(inrq_v[g]), 32'(model_inr(g, d_loaded)));
         end
      end
   endtask

   // Hand-computed vectors for the default bounds 85..120 and the empty range 40..40.
   int   vec_dat [7] = '{84, 85, 119, 120, 0, 127, 100};
   logic vec_inr [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic vec_lo  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
   logic vec_hi  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
   logic emp_lo  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

   initial begin
      clk = 1'b0;
      rst = 1'b1;
      dat = 7'd0;
      #1;
      check_regs("reset", 0, 1'b1);
`ifdef IN_RANGE_CROSSCHECK_EN
      check_eq("reset_mismatch", 32'(mm_v), 32'd0);
`endif

      // Directed vectors, applied while reset is held: combinational path must not care.
      for (int i = 0; i < 7; i++) begin
         dat = 7'(vec_dat[i]);
         #1;
         for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("dir_inr_m%0d_d%0d", g, vec_dat[i]), 32'(inr_v[g]), 32'(vec_inr[i]));
            check_eq($sformatf("dir_lo_m%0d_d%0d", g, vec_dat[i]), 32'(tlo_v[g]), 32'(vec_lo[i]));
            check_eq($sformatf("dir_hi_m%0d_d%0d", g, vec_dat[i]), 32'(thi_v[g]), 32'(vec_hi[i]));
            check_eq($sformatf("dir_full_m%0d_d%0d", g, vec_dat[i]), 32'(inr_v[g+3]), 32'd1);
            check_eq($sformatf("dir_empty_m%0d_d%0d", g, vec_dat[i]), 32'(inr_v[g+6]), 32'd0);
            check_eq($sformatf("dir_empty_lo_m%0d_d%0d", g, vec_dat[i]), 32'(tlo_v[g+6]), 32'(emp_lo[i]));
            check_eq($sformatf("dir_empty_hi_m%0d_d%0d", g, vec_dat[i]), 32'(thi_v[g+6]), 32'(!emp_lo[i]));
         end
      end

      // Clocked path: held in reset across an edge, then 100 then 50.
      @(negedge clk);
      dat = 7'd100;
      @(negedge clk);
      check_regs("held_reset", 100, 1'b1);
      rst = 1'b0;
      @(negedge clk);
      check_regs("load100", 100, 1'b0);
      dat = 7'd50;
      @(negedge clk);
      check_regs("load50", 50, 1'b0);

      // Asynchronous reset mid-cycle while inr_q is high.
      dat = 7'd100;
      @(posedge clk);
      #1;
      check_regs("preasync", 100, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_regs("async_rst", 100, 1'b1);
      check_comb("async_comb");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_regs("post_rst", 100, 1'b0);

      // Exhaustive sweep of dat.
      for (int d = 0; d < 128; d++) begin
         @(negedge clk);
         dat = 7'(d);
         #1;
         check_comb("sweep");
      end

      // Random samples every 50 time units.
      for (int i = 0; i < 1000; i++) begin
         dat = 7'($urandom_range(0, 127));
         #1;
         for (int g = 0; g < 3; g++) begin
            check_eq($sformatf("rand_m%0d_d%0d", g, int'(dat)), 32'(inr_v[g]), 32'(model_inr(g, int'(dat))));
         end
         #49;
      end
`ifdef IN_RANGE_CROSSCHECK_EN
      @(negedge clk);
      check_eq("final_mismatch", 32'(mm_v), 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
